// File: rtl/return_stack_pkg.sv
// Shared constants for the hardware call/return stack.
package return_stack_pkg;

    localparam int unsigned RSTK_MODE_DROP           = 0;
    localparam int unsigned RSTK_MODE_WRAP           = 1;
    localparam int unsigned RSTK_DEPTH_DEFAULT       = 8;
    localparam int unsigned RSTK_DATA_WIDTH_DEFAULT  = 16;

endpackage

// File: rtl/return_stack_stack_ram.sv
// Return-stack storage: Depth x DataWidth registers, synchronous write, asynchronous read.
module stack_ram #(
    parameter int unsigned DataWidth = 16,
    parameter int unsigned Depth     = 8
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [$clog2(Depth)-1:0]   wr_addr,
    input  logic [DataWidth-1:0]       wr_data,
    input  logic [$clog2(Depth)-1:0]   rd_addr,
    output logic [DataWidth-1:0]       rd_data_c
);

    logic [DataWidth-1:0] mem [Depth];

    // Contents are deliberately not reset; the top level masks stale data while empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/return_stack.sv
// Call/return stack: top pointer, entry count, sticky error flags and registered top-of-stack.
module return_stack
    import return_stack_pkg::*;
#(
    parameter int unsigned DataWidth    = RSTK_DATA_WIDTH_DEFAULT,
    parameter int unsigned Depth        = RSTK_DEPTH_DEFAULT,
    parameter int unsigned OverflowMode = RSTK_MODE_DROP
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           Push,
    input  logic                           Pop,
    input  logic [DataWidth-1:0]           DIn,
    input  logic                           ClrErr,
    output logic [DataWidth-1:0]           DOut,
    output logic [$clog2(Depth+1)-1:0]     Count,
    output logic                           Empty,
    output logic                           Full,
    output logic                           Overflow,
    output logic                           Underflow
);

    localparam int unsigned AddrWidth  = $clog2(Depth);
    localparam int unsigned CountWidth = $clog2(Depth + 1);
    localparam bit          WrapMode   = (OverflowMode == RSTK_MODE_WRAP);

    logic [AddrWidth-1:0]  ptr;
    logic [AddrWidth-1:0]  ptr_nxt;
    logic [AddrWidth-1:0]  ptr_inc;
    logic [AddrWidth-1:0]  ptr_dec;
    logic [CountWidth-1:0] count_nxt;
    logic [DataWidth-1:0]  dout_nxt;
    logic                  ovf_set;
    logic                  unf_set;
    logic                  is_empty;
    logic                  is_full;
    logic                  wr_en;
    logic [AddrWidth-1:0]  wr_addr;
    logic [DataWidth-1:0]  rd_data_c;

    stack_ram #(
        .DataWidth (DataWidth),
        .Depth     (Depth)
    ) u_stack_ram (
        .clk       (Clk),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (DIn),
        .rd_addr   (ptr_dec),
        .rd_data_c (rd_data_c)
    );

    // Next-state: the read port always looks at the entry below the top, ready for a pop.
    always_comb begin
        ptr_inc   = ptr + AddrWidth'(1);
        ptr_dec   = ptr - AddrWidth'(1);
        is_empty  = (Count == '0);
        is_full   = (Count == CountWidth'(Depth));
        ptr_nxt   = ptr;
        count_nxt = Count;
        dout_nxt  = DOut;
        wr_en     = 1'b0;
        wr_addr   = ptr_inc;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;

        if (Push && Pop) begin
            wr_en    = 1'b1;
            dout_nxt = DIn;
            if (is_empty) begin
                ptr_nxt   = ptr_inc;
                count_nxt = CountWidth'(1);
            end else begin
                wr_addr = ptr;
            end
        end else if (Push) begin
            if (!is_full) begin
                wr_en     = 1'b1;
                ptr_nxt   = ptr_inc;
                count_nxt = Count + CountWidth'(1);
                dout_nxt  = DIn;
            end else begin
                ovf_set = 1'b1;
                if (WrapMode) begin
                    // The slot above the top is the oldest entry once the ring is full.
                    wr_en    = 1'b1;
                    ptr_nxt  = ptr_inc;
                    dout_nxt = DIn;
                end
            end
        end else if (Pop) begin
            if (!is_empty) begin
                ptr_nxt   = ptr_dec;
                count_nxt = Count - CountWidth'(1);
                dout_nxt  = (Count == CountWidth'(1)) ? '0 : rd_data_c;
            end else begin
                unf_set = 1'b1;
            end
        end
    end

    // State registers; a new error event wins over ClrErr in the same cycle.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ptr       <= '0;
            Count     <= '0;
            DOut      <= '0;
            Empty     <= 1'b1;
            Full      <= 1'b0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            ptr       <= ptr_nxt;
            Count     <= count_nxt;
            DOut      <= dout_nxt;
            Empty     <= (count_nxt == '0);
            Full      <= (count_nxt == CountWidth'(Depth));
            Overflow  <= ovf_set | (Overflow & ~ClrErr);
            Underflow <= unf_set | (Underflow & ~ClrErr);
        end
    end

endmodule

// File: tb/tb_return_stack.sv
// Bench for return_stack: drop-mode and wrap-mode instances (Depth 4) share stimulus, checked against a queue model.
module tb_return_stack;
    import return_stack_pkg::*;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst_n;
    logic          push;
    logic          pop;
    logic [DW-1:0] din;
    logic          clr_err;

    logic [DW-1:0] dout  [2];
    logic [CW-1:0] count [2];
    logic          empty [2];
    logic          full  [2];
    logic          ovf   [2];
    logic          unf   [2];

    logic [DW-1:0] mq [2][$];
    logic          m_ovf [2];
    logic          m_unf [2];

    int checks = 0;
    int errors = 0;

    return_stack #(.DataWidth(DW), .Depth(DEPTH), .OverflowMode(RSTK_MODE_DROP)) u_drop (
        .Clk(clk), .Reset(rst_n), .Push(push), .Pop(pop), .DIn(din), .ClrErr(clr_err),
        .DOut(dout[0]), .Count(count[0]), .Empty(empty[0]), .Full(full[0]),
        .Overflow(ovf[0]), .Underflow(unf[0])
    );

    return_stack #(.DataWidth(DW), .Depth(DEPTH), .OverflowMode(RSTK_MODE_WRAP)) u_wrap (
        .Clk(clk), .Reset(rst_n), .Push(push), .Pop(pop), .DIn(din), .ClrErr(clr_err),
        .DOut(dout[1]), .Count(count[1]), .Empty(empty[1]), .Full(full[1]),
        .Overflow(ovf[1]), .Underflow(unf[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a queue per mode, back = top of stack, front = oldest entry.
    task automatic model_step(input bit p, input bit po, input logic [DW-1:0] d, input bit c);
        for (int k = 0; k < 2; k++) begin
            bit o = 1'b0;
            bit u = 1'b0;
            if (p && po) begin
                if (mq[k].size() == 0) mq[k].push_back(d);
                else mq[k][mq[k].size()-1] = d;
            end else if (p) begin
                if (mq[k].size() < DEPTH) mq[k].push_back(d);
                else begin
                    o = 1'b1;
                    if (k == 1) begin
                        void'(mq[k].pop_front());
                        mq[k].push_back(d);
                    end
                end
            end else if (po) begin
                if (mq[k].size() > 0) void'(mq[k].pop_back());
                else u = 1'b1;
            end
            m_ovf[k] = o | (m_ovf[k] & !c);
            m_unf[k] = u | (m_unf[k] & !c);
        end
    endtask

    // Drive one cycle from just after a falling edge; return just after the next falling edge.
    task automatic drive(input bit p, input bit po, input logic [DW-1:0] d, input bit c);
        push = p; pop = po; din = d; clr_err = c;
        @(posedge clk);
        model_step(p, po, d, c);
        @(negedge clk);
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        push = 1'b0; pop = 1'b0; clr_err = 1'b0; din = '0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            m_ovf[k] = 1'b0;
            m_unf[k] = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        drive(1, 0, 16'h00a1, 0);
        drive(1, 0, 16'h00a2, 0);
        drive(1, 0, 16'h00a3, 0);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (count[k] !== '0 || empty[k] !== 1'b1 || full[k] !== 1'b0 || dout[k] !== '0
                || ovf[k] !== 1'b0 || unf[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d]: got cnt=%0d emp=%b full=%b dout=%h ovf=%b unf=%b want 0 1 0 0000 0 0",
                         k, count[k], empty[k], full[k], dout[k], ovf[k], unf[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            m_ovf[k] = 1'b0;
            m_unf[k] = 1'b0;
        end
    endtask

    task automatic test_push_pop();
        logic [DW-1:0] exp_d [6] = '{16'h0010, 16'h0020, 16'h0030, 16'h0020, 16'h0010, 16'h0000};
        int            exp_c [6] = '{1, 2, 3, 2, 1, 0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i < 3) drive(1, 0, DW'((i + 1) * 16), 0);
            else drive(0, 1, 16'hdead, 0);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (dout[k] !== exp_d[i] || count[k] !== CW'(exp_c[i]) || empty[k] !== (exp_c[i] == 0)) begin
                    errors++;
                    $display("FAIL push_pop[%0d] step %0d: got dout=%h cnt=%0d emp=%b want %h %0d %b",
                             k, i, dout[k], count[k], empty[k], exp_d[i], exp_c[i], exp_c[i] == 0);
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] pop_d [2][4] = '{'{16'h3, 16'h2, 16'h1, 16'h0}, '{16'h4, 16'h3, 16'h2, 16'h0}};
        do_reset();
        for (int i = 1; i <= 5; i++) drive(1, 0, DW'(i), 0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (dout[k] !== DW'(4 + k) || count[k] !== CW'(4) || full[k] !== 1'b1 || ovf[k] !== 1'b1) begin
                errors++;
                $display("FAIL overflow[%0d]: got dout=%h cnt=%0d full=%b ovf=%b want %h 4 1 1",
                         k, dout[k], count[k], full[k], ovf[k], DW'(4 + k));
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, '0, 0);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (dout[k] !== pop_d[k][i] || count[k] !== CW'(3 - i) || full[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_pop[%0d] step %0d: got dout=%h cnt=%0d full=%b want %h %0d 0",
                             k, i, dout[k], count[k], full[k], pop_d[k][i], 3 - i);
                end
            end
        end
    endtask

    task automatic test_underflow();
        logic exp_u [3] = '{1'b1, 1'b1, 1'b0};
        do_reset();
        drive(0, 1, '0, 0);
        drive(0, 1, '0, 1);
        drive(0, 0, '0, 1);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (unf[k] !== exp_u[2] || count[k] !== '0 || dout[k] !== '0 || empty[k] !== 1'b1) begin
                errors++;
                $display("FAIL underflow_clr[%0d]: got unf=%b cnt=%0d dout=%h want 0 0 0000", k, unf[k], count[k], dout[k]);
            end
        end
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, '0, i == 1);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (unf[k] !== exp_u[i] || count[k] !== '0 || dout[k] !== '0) begin
                    errors++;
                    $display("FAIL underflow[%0d] step %0d: got unf=%b cnt=%0d dout=%h want %b 0 0000",
                             k, i, unf[k], count[k], dout[k], exp_u[i]);
                end
            end
        end
    endtask

    task automatic test_replace();
        do_reset();
        drive(1, 0, 16'h0030, 0);
        drive(1, 0, 16'h0040, 0);
        drive(1, 1, 16'h0099, 0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (dout[k] !== 16'h0099 || count[k] !== CW'(2) || ovf[k] !== 1'b0 || unf[k] !== 1'b0) begin
                errors++;
                $display("FAIL replace[%0d]: got dout=%h cnt=%0d ovf=%b unf=%b want 0099 2 0 0", k, dout[k], count[k], ovf[k], unf[k]);
            end
        end
        drive(0, 1, '0, 0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (dout[k] !== 16'h0030 || count[k] !== CW'(1)) begin
                errors++;
                $display("FAIL replace_pop[%0d]: got dout=%h cnt=%0d want 0030 1", k, dout[k], count[k]);
            end
        end
        do_reset();
        drive(1, 1, 16'h0077, 0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (dout[k] !== 16'h0077 || count[k] !== CW'(1) || unf[k] !== 1'b0 || empty[k] !== 1'b0) begin
                errors++;
                $display("FAIL replace_empty[%0d]: got dout=%h cnt=%0d unf=%b emp=%b want 0077 1 0 0",
                         k, dout[k], count[k], unf[k], empty[k]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            bit            p  = ($urandom_range(0, 99) < 50);
            bit            po = ($urandom_range(0, 99) < 45);
            bit            c  = ($urandom_range(0, 99) < 8);
            logic [DW-1:0] d  = DW'($urandom);
            drive(p, po, d, c);
            for (int k = 0; k < 2; k++) begin
                int            sz    = mq[k].size();
                logic [DW-1:0] e_d   = (sz > 0) ? mq[k][sz-1] : '0;
                checks++;
                if (dout[k] !== e_d || count[k] !== CW'(sz) || empty[k] !== (sz == 0)
                    || full[k] !== (sz == DEPTH) || ovf[k] !== m_ovf[k] || unf[k] !== m_unf[k]) begin
                    errors++;
                    $display("FAIL random[%0d] cyc %0d: got dout=%h cnt=%0d emp=%b full=%b ovf=%b unf=%b want %h %0d %b %b %b %b",
                             k, n, dout[k], count[k], empty[k], full[k], ovf[k], unf[k],
                             e_d, sz, sz == 0, sz == DEPTH, m_ovf[k], m_unf[k]);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; push = 1'b0; pop = 1'b0; din = '0; clr_err = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_ovf[k] = 1'b0;
            m_unf[k] = 1'b0;
        end
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_replace();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/return_stack.md
Name: return_stack

Overview:
Parametrised hardware call/return stack that replaces the CPU's single-entry return-address register, so calls can nest to Depth levels.
- Sits between the PC (push source) and the PC-source mux (return-address input).
- The sequence-control matrix drives Push/Pop.
- Reports fullness and sticky error flags so the control matrix can halt or trap on overflow or underflow.

Parameters:
DataWidth, 16, width of each stored entry (return address).
Depth, 8, number of entries; power of two, minimum 2.
OverflowMode, 0, behaviour on push when full: 0 = drop (reject the push), 1 = wrap (circular, overwrite the oldest entry).

Ports:
Clk  input  1  system clock, rising edge.
Reset  input  1  asynchronous, active-low reset.
Push  input  1  write DIn as the new top of stack.
Pop  input  1  remove the top entry.
DIn  input  DataWidth  value to push (PC of the next instruction).
ClrErr  input  1  synchronous clear of Overflow and Underflow.
DOut  output  DataWidth  current top entry; 0 when empty.
Count  output  clog2(Depth+1)  number of valid entries, 0..Depth.
Empty  output  1  Count == 0.
Full  output  1  Count == Depth.
Overflow  output  1  sticky; set by a push while full.
Underflow  output  1  sticky; set by a pop while empty.

Behaviour:
- Reset (Reset low, asynchronous): top pointer = 0, Count = 0, Overflow = 0, Underflow = 0, DOut = 0, Empty = 1, Full = 0. Storage contents are not reset; DOut is forced to 0 while Empty.
- All updates occur on the rising Clk edge. DOut, Count, Empty and Full are valid the cycle after the edge. There is no combinational path from Push/Pop to DOut.
- Push only, not full: mem[top+1] = DIn; top increments modulo Depth; Count increments; next-cycle DOut = DIn.
- Push only, full, OverflowMode 0: no storage, pointer or Count change; Overflow set.
- Push only, full, OverflowMode 1: top increments modulo Depth; DIn overwrites the oldest entry; Count stays at Depth; Overflow set.
- Pop only, not empty: top decrements modulo Depth; Count decrements; DOut shows the previous entry, or 0 if Count becomes 0.
- Pop only, empty: no state change other than Underflow set; DOut stays 0.
- Push and Pop together, not empty: replace the top entry (mem[top] = DIn). Count and pointer are unchanged; no flag is set, even when full.
- Push and Pop together, empty: behaves as a push; Count becomes 1; no Underflow.
- ClrErr clears both sticky flags. If ClrErr coincides with a new error event in the same cycle, the flag is set (set wins over clear).
- Pointer and Count arithmetic:
  - The pointer is clog2(Depth) bits and wraps naturally.
  - Count saturates at Depth and never wraps past Depth or below 0.
- Flags are independent of Push/Pop legality checks upstream; the block never blocks the CPU.

Decomposition:
- Shared constants file:
  - OverflowMode encodings RSTK_MODE_DROP = 0 and RSTK_MODE_WRAP = 1.
  - Default Depth.
- One natural sub-module: stack_ram. It is a Depth x DataWidth register array with a synchronous write port and an asynchronous read port addressed by the pointer. It has no reset.
- return_stack holds the pointer, Count, flags and next-state logic, and registers DOut.

Test Plan:
1. Reset low mid-operation after 3 pushes, then release -> Count = 0, Empty = 1, DOut = 0, flags = 0 in the same cycle Reset asserts.
2. Depth = 4: push 0x0010, 0x0020, 0x0030, then pop 3x -> DOut sequence 0x0010, 0x0020, 0x0030, then 0x0020, 0x0010, 0x0000; Count 1, 2, 3, 2, 1, 0; Empty on the final cycle.
3. Depth = 4, OverflowMode = 0: push 0x1..0x4, then push 0x5 -> Full = 1, Overflow = 1, DOut = 0x4, Count = 4. Pop 4x -> 0x3, 0x2, 0x1, then Empty.
4. Depth = 4, OverflowMode = 1: push 0x1..0x5 -> Overflow = 1, Count = 4, DOut = 0x5. Pop 3x -> 0x4, 0x3, 0x2, then Count = 1 with DOut = 0x2.
5. Pop while empty -> Underflow = 1, Count = 0, DOut = 0. ClrErr together with another empty pop -> Underflow remains 1. ClrErr alone -> Underflow = 0.
6. Push and Pop together with Count = 2, top = 0x0040, DIn = 0x0099 -> DOut = 0x0099, Count = 2, no flags. Push and Pop together when empty with DIn = 0x0077 -> Count = 1, DOut = 0x0077, Underflow = 0.
